bus_readback_mux: RTL and testbench
===================================

BUS_READBACK_MUX -- requirements
Module: bus_readback_mux

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 8, number of select/data channels (2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of each slave read-data bus and of DataOut_CPU.
REQ-003 SHALL have parameter WAIT_WIDTH, default 4, width of each per-slave wait-state field.
REQ-004 SHALL have parameter IDX_WIDTH, default $clog2(NUM_SLAVES), width of Active_Index.
REQ-005 SHALL have port Clock  input  1  single system clock, all logic on rising edge.
REQ-006 SHALL have port Reset_H  input  1  synchronous active-high reset.
REQ-007 SHALL have port AS_L  input  1  CPU address strobe, active low.
REQ-008 SHALL have port WE_L  input  1  CPU write enable, active low (0 = write cycle).
REQ-009 SHALL have port Select_H  input  NUM_SLAVES  one-hot-intended slave selects from address decoder.
REQ-010 SHALL have port DataIn_Slaves  input  NUM_SLAVES*DATA_WIDTH  packed slave read data, slave k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port WaitStates  input  NUM_SLAVES*WAIT_WIDTH  static per-slave wait-state counts, slave k at [k*WAIT_WIDTH +: WAIT_WIDTH].
REQ-012 SHALL have port DataOut_CPU  output  DATA_WIDTH  registered read data to CPU.
REQ-013 SHALL have port DTAck_H  output  1  one-cycle data-transfer-acknowledge pulse.
REQ-014 SHALL have port Bus_Error_H  output  1  one-cycle pulse coincident with DTAck_H when no slave was selected.
REQ-015 SHALL have port Multi_Select_Err_H  output  1  sticky flag, set when more than one select was active at cycle start.
REQ-016 SHALL have port Active_Index  output  IDX_WIDTH  index of slave captured for the current/last cycle.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, ACK, RELEASE.
REQ-018 IDLE: when AS_L==0, SHALL latch winner = lowest-index asserted Select_H bit, load counter with that slave's WaitStates field, latch WE_L, go WAIT.
REQ-019 IDLE with AS_L==0 and Select_H all zero SHALL mark cycle unmapped, load counter 0, go WAIT.
REQ-020 IDLE with AS_L==0 and two or more Select_H bits set SHALL set Multi_Select_Err_H (sticky until reset); lowest index still wins.
REQ-021 WAIT: counter nonzero SHALL decrement by 1 and stay; counter zero SHALL go ACK and, for read cycles, capture winner's data into DataOut_CPU (unmapped read captures all zeros).
REQ-022 Write cycles SHALL leave DataOut_CPU unchanged but follow identical wait/ack timing.
REQ-023 ACK: DTAck_H SHALL be 1 for exactly this cycle, Bus_Error_H 1 here only if unmapped; then go RELEASE.
REQ-024 RELEASE: SHALL hold until AS_L==1, then go IDLE; no second DTAck_H per strobe.
REQ-025 AS_L==1 observed in WAIT SHALL abort to IDLE with no DTAck_H, no capture, Active_Index unchanged from latch.
REQ-026 Latency: AS_L first sampled low at edge T -> DTAck_H high in cycle T+2+W, W = winner's wait states (0..2^WAIT_WIDTH-1).
REQ-027 DataOut_CPU SHALL hold last captured value until next read capture or reset.
REQ-028 Active_Index SHALL update at the IDLE->WAIT transition; 0 for unmapped cycles.
REQ-029 Select_H/DataIn_Slaves changes after the IDLE sample SHALL not change the winner; data is sampled only at the capture edge.

Reset
REQ-030 Reset_H==1 at a rising edge SHALL force IDLE, counter 0, DataOut_CPU 0, DTAck_H 0, Bus_Error_H 0, Multi_Select_Err_H 0, Active_Index 0, overriding any state including mid-WAIT.
REQ-031 Reset SHALL take priority over every simultaneous event.

Verification
REQ-032 Select_H=8'b0000_0100, WaitStates[2]=0, slave2 data 32'hDEADBEEF, AS_L low at T -> DTAck_H at T+2, DataOut_CPU=32'hDEADBEEF, Active_Index=2.
REQ-033 Select_H=8'b0000_0010, WaitStates[1]=5, read -> DTAck_H at T+7, exactly one pulse while AS_L held low 20 cycles.
REQ-034 Select_H=8'b0010_1000 -> Active_Index=3, slave3 data returned, Multi_Select_Err_H=1 and stays 1 over next clean cycle.
REQ-035 Select_H=0, AS_L low -> DTAck_H and Bus_Error_H both high at T+2, DataOut_CPU=0.
REQ-036 WaitStates[0]=15, AS_L raised at T+4 -> no DTAck_H, DataOut_CPU keeps previous value; next strobe acks normally.
REQ-037 Reset_H pulsed at T+3 of a 10-wait cycle -> all outputs 0 next edge, no DTAck_H; write cycle (WE_L=0) -> DTAck_H timing per REQ-026, DataOut_CPU unchanged.

Source files
------------

// File: rtl/bus_readback_mux_if.sv
// CPU-side read-back bus bundle: strobes, slave selects/data/wait fields and the CPU response.
// The mux itself connects to the slave modport.
interface bus_readback_mux_if #(
    parameter int unsigned NUM_SLAVES = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WAIT_WIDTH = 4,
    parameter int unsigned IDX_WIDTH  = $clog2(NUM_SLAVES)
);
    logic                             AS_L;
    logic                             WE_L;
    logic [NUM_SLAVES-1:0]            Select_H;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] DataIn_Slaves;
    logic [NUM_SLAVES*WAIT_WIDTH-1:0] WaitStates;
    logic [DATA_WIDTH-1:0]            DataOut_CPU;
    logic                             DTAck_H;
    logic                             Bus_Error_H;
    logic                             Multi_Select_Err_H;
    logic [IDX_WIDTH-1:0]             Active_Index;

    modport master (
        output AS_L, WE_L, Select_H, DataIn_Slaves, WaitStates,
        input  DataOut_CPU, DTAck_H, Bus_Error_H, Multi_Select_Err_H, Active_Index
    );

    modport slave (
        input  AS_L, WE_L, Select_H, DataIn_Slaves, WaitStates,
        output DataOut_CPU, DTAck_H, Bus_Error_H, Multi_Select_Err_H, Active_Index
    );
endinterface

// File: rtl/bus_readback_mux.sv
// Read-back multiplexer: picks the lowest-index selected slave, inserts its wait states,
// returns registered read data with a one-cycle DTAck_H (plus Bus_Error_H when unmapped).
module bus_readback_mux #(
    parameter int unsigned NUM_SLAVES = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WAIT_WIDTH = 4,
    parameter int unsigned IDX_WIDTH  = $clog2(NUM_SLAVES)
) (
    input  logic                 Clock,
    input  logic                 Reset_H,
    bus_readback_mux_if.slave    bus
);

    typedef enum logic [1:0] {StIdle, StWait, StAck, StRelease} state_e;

    state_e                state_q, state_d;
    logic [WAIT_WIDTH-1:0] cnt_q, cnt_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic                  mapped_q, mapped_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  dtack_q, dtack_d;
    logic                  berr_q, berr_d;
    logic                  multi_q, multi_d;

    logic [IDX_WIDTH-1:0]  win_idx;
    logic [WAIT_WIDTH-1:0] win_wait;
    logic                  any_sel;
    logic                  multi_sel;
    logic [DATA_WIDTH-1:0] sel_data;

    // First set bit found in ascending order is the winner.
    always_comb begin
        win_idx  = '0;
        win_wait = '0;
        any_sel  = 1'b0;
        for (int k = 0; k < int'(NUM_SLAVES); k++) begin
            if (!any_sel && bus.Select_H[k]) begin
                any_sel  = 1'b1;
                win_idx  = IDX_WIDTH'(k);
                win_wait = bus.WaitStates[k*WAIT_WIDTH +: WAIT_WIDTH];
            end
        end
        multi_sel = (bus.Select_H & (bus.Select_H - NUM_SLAVES'(1))) != '0;
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < int'(NUM_SLAVES); k++) begin
            if (idx_q == IDX_WIDTH'(k)) begin
                sel_data = bus.DataIn_Slaves[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        mapped_d = mapped_q;
        write_d  = write_q;
        data_d   = data_q;
        dtack_d  = 1'b0;
        berr_d   = 1'b0;
        multi_d  = multi_q;
        unique case (state_q)
            StIdle: begin
                if (!bus.AS_L) begin
                    state_d  = StWait;
                    idx_d    = win_idx;
                    mapped_d = any_sel;
                    write_d  = !bus.WE_L;
                    cnt_d    = win_wait;
                    if (multi_sel) multi_d = 1'b1;
                end
            end
            StWait: begin
                // A released strobe aborts before any acknowledge or capture.
                if (bus.AS_L) begin
                    state_d = StIdle;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - WAIT_WIDTH'(1);
                end else begin
                    state_d = StAck;
                    dtack_d = 1'b1;
                    berr_d  = !mapped_q;
                    if (!write_q) data_d = mapped_q ? sel_data : '0;
                end
            end
            StAck: begin
                state_d = StRelease;
            end
            StRelease: begin
                if (bus.AS_L) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset_H) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            idx_q    <= '0;
            mapped_q <= 1'b0;
            write_q  <= 1'b0;
            data_q   <= '0;
            dtack_q  <= 1'b0;
            berr_q   <= 1'b0;
            multi_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            mapped_q <= mapped_d;
            write_q  <= write_d;
            data_q   <= data_d;
            dtack_q  <= dtack_d;
            berr_q   <= berr_d;
            multi_q  <= multi_d;
        end
    end

    assign bus.DataOut_CPU        = data_q;
    assign bus.DTAck_H            = dtack_q;
    assign bus.Bus_Error_H        = berr_q;
    assign bus.Multi_Select_Err_H = multi_q;
    assign bus.Active_Index       = idx_q;

endmodule

// File: tb/tb_bus_readback_mux.sv
// Scoreboard bench for bus_readback_mux: directed strobes push expected acks, a negedge
// monitor pops and compares data, error flag, index and ack cycle.
module tb_bus_readback_mux;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bus_readback_mux_if #(.NUM_SLAVES(8), .DATA_WIDTH(32), .WAIT_WIDTH(4), .IDX_WIDTH(3)) bus ();

    bus_readback_mux #(.NUM_SLAVES(8), .DATA_WIDTH(32), .WAIT_WIDTH(4), .IDX_WIDTH(3)) dut (
        .Clock   (clk),
        .Reset_H (rst),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          idx;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ack_cnt = 0;
    int   base_ack = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Cycle number of the clock period ending at the next rising edge is cyc+1.
    always @(negedge clk) begin
        if (bus.DTAck_H === 1'b1) begin
            ack_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: DTAck_H high at cycle %0d with nothing pending",
                         cyc + 1);
            end else begin
                e = exp_q.pop_front();
                chk("ack_data", bus.DataOut_CPU, e.data);
                chk("ack_bus_error", 32'(bus.Bus_Error_H), 32'(e.err));
                chk("ack_index", 32'(bus.Active_Index), e.idx);
                chk("ack_cycle", cyc + 1, e.cyc);
            end
        end else if (bus.Bus_Error_H === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL lone_bus_error: Bus_Error_H high without DTAck_H at cycle %0d", cyc + 1);
        end
    end

    task automatic set_slave(input int k, input logic [31:0] v);
        bus.DataIn_Slaves[k*32 +: 32] = v;
    endtask

    task automatic set_wait(input int k, input logic [3:0] v);
        bus.WaitStates[k*4 +: 4] = v;
    endtask

    // Drops AS_L after the current edge; first sampled low at edge T = cyc+1.
    task automatic start_cycle(input logic [7:0] sel, input logic we_n, input logic want_ack,
                               input logic [31:0] data, input logic err, input int idx,
                               input int w);
        exp_t x;
        @(posedge clk); #1;
        bus.Select_H = sel;
        bus.WE_L     = we_n;
        bus.AS_L     = 1'b0;
        base_ack     = ack_cnt;
        if (want_ack) begin
            x.data = data;
            x.err  = err;
            x.idx  = idx;
            x.cyc  = cyc + 1 + 2 + w;
            exp_q.push_back(x);
        end
    endtask

    task automatic wait_ack(input int w, input int hold);
        int i;
        i = 0;
        while (ack_cnt == base_ack && i < w + 8) begin
            @(posedge clk); #1;
            i++;
        end
        if (ack_cnt == base_ack) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: no DTAck_H within %0d cycles", w + 8);
            if (exp_q.size() > 0) exp_q.delete(0);
        end
        repeat (hold) begin @(posedge clk); #1; end
        chk("one_ack_per_strobe", ack_cnt - base_ack, 1);
        bus.AS_L = 1'b1;
        bus.WE_L = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"}, bus.DataOut_CPU, 32'h0);
        chk({tag, "_dtack"}, 32'(bus.DTAck_H), 32'h0);
        chk({tag, "_berr"}, 32'(bus.Bus_Error_H), 32'h0);
        chk({tag, "_multi"}, 32'(bus.Multi_Select_Err_H), 32'h0);
        chk({tag, "_index"}, 32'(bus.Active_Index), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst               = 1'b1;
        bus.AS_L          = 1'b1;
        bus.WE_L          = 1'b1;
        bus.Select_H      = '0;
        bus.DataIn_Slaves = '0;
        bus.WaitStates    = '0;
        set_slave(0, 32'hA0A0_A0A0);
        set_slave(1, 32'hCAFE_0001);
        set_slave(2, 32'hDEAD_BEEF);
        set_slave(3, 32'h3333_3333);
        set_slave(5, 32'h5555_5555);
        set_slave(6, 32'h6666_6666);
        set_wait(0, 4'd15);
        set_wait(1, 4'd5);
        set_wait(3, 4'd2);
        set_wait(4, 4'd10);
        set_wait(5, 4'd1);
        set_wait(6, 4'd3);
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        // Single select, zero waits.
        start_cycle(8'b0000_0100, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 2, 0);
        wait_ack(0, 1);

        // Five waits, strobe held ~20 cycles; later select/data changes must not move the winner
        // but the capture-edge data is what returns.
        start_cycle(8'b0000_0010, 1'b1, 1'b1, 32'hCAFE_0002, 1'b0, 1, 5);
        @(posedge clk); #1;
        bus.Select_H = 8'b1000_0000;
        set_slave(1, 32'hCAFE_0002);
        wait_ack(5, 14);

        // Two selects: lowest wins, sticky error survives a following clean cycle.
        start_cycle(8'b0010_1000, 1'b1, 1'b1, 32'h3333_3333, 1'b0, 3, 2);
        wait_ack(2, 1);
        chk("multi_set", 32'(bus.Multi_Select_Err_H), 32'h1);
        start_cycle(8'b0100_0000, 1'b1, 1'b1, 32'h6666_6666, 1'b0, 6, 3);
        wait_ack(3, 1);
        chk("multi_sticky", 32'(bus.Multi_Select_Err_H), 32'h1);

        // Write: same timing, read data register untouched.
        start_cycle(8'b0010_0000, 1'b0, 1'b1, 32'h6666_6666, 1'b0, 5, 1);
        wait_ack(1, 1);

        // Unmapped read.
        start_cycle(8'b0000_0000, 1'b1, 1'b1, 32'h0, 1'b1, 0, 0);
        wait_ack(0, 1);

        // Abort mid-wait: prior data held, index latched from the aborted strobe.
        start_cycle(8'b0000_0100, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 2, 0);
        wait_ack(0, 1);
        n = ack_cnt;
        start_cycle(8'b0000_0001, 1'b1, 1'b0, 32'h0, 1'b0, 0, 15);
        repeat (4) @(posedge clk);
        #1;
        bus.AS_L = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_data_held", bus.DataOut_CPU, 32'hDEAD_BEEF);
        chk("abort_index", 32'(bus.Active_Index), 32'h0);
        chk("abort_no_ack", ack_cnt - n, 0);
        set_wait(0, 4'd1);
        start_cycle(8'b0000_0001, 1'b1, 1'b1, 32'hA0A0_A0A0, 1'b0, 0, 1);
        wait_ack(1, 1);

        // Reset in the middle of a ten-wait cycle, with the sticky flag set beforehand.
        start_cycle(8'b0001_1000, 1'b1, 1'b1, 32'h3333_3333, 1'b0, 3, 2);
        wait_ack(2, 1);
        n = ack_cnt;
        start_cycle(8'b0001_0000, 1'b1, 1'b0, 32'h0, 1'b0, 0, 10);
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b1;
        bus.AS_L = 1'b1;
        @(posedge clk);
        #1;
        chk_all_zero("midwait_reset");
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("reset_no_ack", ack_cnt - n, 0);

        // Write after reset keeps DataOut_CPU at its reset value.
        start_cycle(8'b0000_0100, 1'b0, 1'b1, 32'h0, 1'b0, 2, 0);
        wait_ack(0, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
